palindrome_req_arbiter: RTL
===========================

Name: palindrome_req_arbiter

Overview:
- Shares one combinational palindrome checker among NUM_REQ independent requesters.
- Round-robin arbitration; each requester uses a valid/ready handshake.
- The result of each accepted word is registered into a single response slot, tagged with the requester id.
- Sits between producer ports and a downstream consumer. Also keeps a saturating count of palindromes detected.

Parameters:
- NUM_REQ, 4, number of requesters (≥2).
- DATA_WIDTH, 32, width of each request word.
- CNT_WIDTH, 16, width of the palindrome hit counter.
- ID_W (localparam), $clog2(NUM_REQ), requester id width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- resetn  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_data  in  NUM_REQ*DATA_WIDTH  packed words; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_ready  out  NUM_REQ  one-hot grant/accept; at most one bit set per cycle.
- rsp_valid  out  1  response slot holds a result.
- rsp_id  out  ID_W  index of the requester whose word produced the result.
- rsp_pal  out  1  1 if that word's binary representation, including leading zeros, is a palindrome.
- rsp_ready  in  1  consumer accepts response.
- pal_cnt  out  CNT_WIDTH  saturating count of accepted words that were palindromes.

Behaviour:
- Reset (resetn=0, asynchronous):
  - rsp_valid=0, rsp_id=0, rsp_pal=0, pal_cnt=0.
  - Round-robin pointer ptr=0.
  - req_ready=0 while reset is asserted.
  - Reset mid-transfer drops a pending response with no other side effect.
- Output slot FSM has two states:
  - EMPTY (rsp_valid=0).
  - FULL (rsp_valid=1).
- can_accept = !rsp_valid || rsp_ready. This allows a simultaneous drain and refill, so throughput is 1 word/cycle.
- Arbitration (combinational):
  - If can_accept and any req_valid, the grant g is the first index with req_valid set, scanning ptr, ptr+1, … with wrap modulo NUM_REQ.
  - req_ready = one-hot(g); otherwise req_ready=0.
  - req_ready depends on req_valid. Requesters must not make req_valid depend on req_ready.
- Transfer occurs when req_valid[g] && req_ready[g]. On that edge:
  - rsp_valid←1, rsp_id←g.
  - rsp_pal←palindrome(req_data slice g).
  - ptr←(g+1) mod NUM_REQ; the wrap applies when NUM_REQ is not a power of two.
- Latency: result is visible the cycle after acceptance.
- Drain only (rsp_valid && rsp_ready, no transfer): rsp_valid←0; rsp_id and rsp_pal hold their last values.
- Backpressure (rsp_valid && !rsp_ready): req_ready=0; rsp_valid, rsp_id and rsp_pal are held stable; ptr is unchanged.
- No requests: ptr is unchanged and the slot follows the drain rule.
- pal_cnt increments by 1 on each transfer whose computed result is 1. It saturates at 2^CNT_WIDTH−1 and never wraps.
- Palindrome rule: bit i equals bit DATA_WIDTH−1−i for all i < DATA_WIDTH/2. For odd widths the middle bit is ignored. Width 1 is always a palindrome.
- A requester that deasserts req_valid before it is granted loses nothing; no state is kept per requester.

Decomposition:
- Shared package palindrome_pkg:
  - rsp_state_e enum {RSP_EMPTY, RSP_FULL}.
  - Function rr_next(ptr, NUM_REQ) for the pointer wrap.
- Sub-module: instantiate the existing palindrome_detect (parameter DATA_WIDTH) once, fed by the granted slice through a NUM_REQ:1 mux.
- The round-robin picker stays inline. Splitting it out as rr_pick is permitted if it is reused elsewhere.

Test Plan:
All scenarios use NUM_REQ=4 and DATA_WIDTH=8 unless stated otherwise.
1. Reset: assert resetn=0 mid-cycle with rsp_valid=1 → rsp_valid, pal_cnt, rsp_id and req_ready go to 0 immediately (no clock edge needed); the first grant after release goes to requester 0.
2. Single request: req_valid=4'b0010, data[1]=8'b1000_0001, rsp_ready=1 → req_ready=4'b0010 in the same cycle; next cycle rsp_valid=1, rsp_id=1, rsp_pal=1, pal_cnt=1. Repeat with 8'b1000_0010 → rsp_pal=0, pal_cnt stays 1.
3. Fairness: all req_valid=1 continuously, rsp_ready=1 → grants 0,1,2,3,0,1 on consecutive cycles; one rsp_valid pulse per cycle with matching rsp_id.
4. Backpressure: slot FULL with rsp_id=2, rsp_ready=0 for 3 cycles → req_ready=0 and rsp outputs stable. Raise rsp_ready → same-cycle accept of requester 3 (ptr=3); next cycle rsp_id=3.
5. Saturation: CNT_WIDTH=2, five palindrome words (8'hFF, 8'h00, 8'h81, 8'h3C, 8'h18) → pal_cnt sequence 1,2,3,3,3.
6. Non-power-of-two wrap: NUM_REQ=3, all valid → grants 0,1,2,0; the id never reaches 3.

Source files
------------

// File: rtl/palindrome_pkg.sv
// Shared types and helpers for the palindrome request arbiter.
//   rsp_state_e : occupancy of the single response slot.
//   rr_next     : round-robin pointer advance with wrap at num_req, so
//                 requester counts that are not a power of two wrap correctly.
package palindrome_pkg;

    typedef enum logic {
        RSP_EMPTY = 1'b0,
        RSP_FULL  = 1'b1
    } rsp_state_e;

    function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned num_req);
        return (ptr + 1 >= num_req) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/palindrome_detect.sv
// Combinational bit-palindrome detector.
//   data   : word under test (all DATA_WIDTH bits, leading zeros included).
//   is_pal : 1 when bit i equals bit DATA_WIDTH-1-i for every i < DATA_WIDTH/2.
// The middle bit of an odd-width word never takes part; a 1-bit word is
// trivially a palindrome because the loop body never runs.
module palindrome_detect #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] data,
    output logic                  is_pal
);

    always_comb begin
        is_pal = 1'b1;
        for (int unsigned i = 0; i < DATA_WIDTH / 2; i++) begin
            if (data[i] != data[DATA_WIDTH-1-i]) begin
                is_pal = 1'b0;
            end
        end
    end

endmodule

// File: rtl/palindrome_req_arbiter.sv
// Round-robin arbiter sharing one palindrome detector among NUM_REQ requesters.
//   clk       : clock, all state on the rising edge.
//   resetn    : asynchronous active-low reset.
//   req_valid : per-requester valid.
//   req_data  : packed words, requester i at [i*DATA_WIDTH +: DATA_WIDTH].
//   req_ready : one-hot grant; combinationally depends on req_valid.
//   rsp_valid : response slot holds a result.
//   rsp_id    : requester whose word produced the result.
//   rsp_pal   : palindrome result for that word.
//   rsp_ready : consumer takes the response.
//   pal_cnt   : saturating count of accepted palindromic words.
// The slot may be drained and refilled on the same edge, giving one word per cycle.
module palindrome_req_arbiter
    import palindrome_pkg::*;
#(
    parameter  int unsigned NUM_REQ    = 4,
    parameter  int unsigned DATA_WIDTH = 32,
    parameter  int unsigned CNT_WIDTH  = 16,
    localparam int unsigned ID_W       = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          rsp_valid,
    output logic [ID_W-1:0]               rsp_id,
    output logic                          rsp_pal,
    input  logic                          rsp_ready,
    output logic [CNT_WIDTH-1:0]          pal_cnt
);

    rsp_state_e             state_q, state_d;
    logic [ID_W-1:0]        ptr_q, ptr_d;
    logic [ID_W-1:0]        rsp_id_q, rsp_id_d;
    logic                   rsp_pal_q, rsp_pal_d;
    logic [CNT_WIDTH-1:0]   pal_cnt_q, pal_cnt_d;

    logic                   can_accept;
    logic                   grant_found;
    int unsigned            grant_sel;
    int unsigned            cand;
    logic [ID_W-1:0]        grant_idx;
    logic [DATA_WIDTH-1:0]  grant_word;
    logic                   word_pal;
    logic                   transfer;

    assign rsp_valid  = (state_q == RSP_FULL);
    assign can_accept = !rsp_valid || rsp_ready;

    // Scan ptr, ptr+1, ... with wrap; first valid requester wins.
    always_comb begin
        grant_found = 1'b0;
        grant_sel   = 0;
        cand        = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = 32'(ptr_q) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_sel   = cand;
            end
        end
    end

    assign grant_idx = grant_sel[ID_W-1:0];

    // Grant suppressed while reset is held: the empty slot would otherwise accept.
    always_comb begin
        req_ready = '0;
        if (resetn && can_accept && grant_found) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    assign transfer = |req_ready;

    always_comb begin
        grant_word = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (k == grant_sel) begin
                grant_word = req_data[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    palindrome_detect #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_detect (
        .data   (grant_word),
        .is_pal (word_pal)
    );

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        rsp_id_d  = rsp_id_q;
        rsp_pal_d = rsp_pal_q;
        pal_cnt_d = pal_cnt_q;
        if (transfer) begin
            state_d   = RSP_FULL;
            rsp_id_d  = grant_idx;
            rsp_pal_d = word_pal;
            ptr_d     = ID_W'(rr_next(grant_sel, NUM_REQ));
            if (word_pal && (pal_cnt_q != '1)) begin
                pal_cnt_d = pal_cnt_q + CNT_WIDTH'(1);
            end
        end else if (rsp_valid && rsp_ready) begin
            // Drain only: id and result keep their last values.
            state_d = RSP_EMPTY;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= RSP_EMPTY;
            ptr_q     <= '0;
            rsp_id_q  <= '0;
            rsp_pal_q <= 1'b0;
            pal_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            rsp_id_q  <= rsp_id_d;
            rsp_pal_q <= rsp_pal_d;
            pal_cnt_q <= pal_cnt_d;
        end
    end

    assign rsp_id  = rsp_id_q;
    assign rsp_pal = rsp_pal_q;
    assign pal_cnt = pal_cnt_q;

    a_grant_onehot : assert property (@(posedge clk) disable iff (!resetn)
        $onehot0(req_ready));

    a_rsp_stable : assert property (@(posedge clk) disable iff (!resetn)
        (rsp_valid && !rsp_ready) |=> (rsp_valid && $stable(rsp_id) && $stable(rsp_pal)));

endmodule
